// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin write arbiter in front of one dfifo write port.
// NREQ producers compete for the port. The winner keeps the port for a burst
// of up to MAXBURST words. The block never writes while fifo_full is high.
//
// Handshake: req[i] acts as "valid". gnt[i] acts as "ready" and is combinational.
// A word moves on the posedge where req[i] & gnt[i]. Producer i holds its din
// slice stable while req[i] is high. It may change the slice only after that
// posedge.
//
// Ports:
//   clk        clock, all state on posedge
//   rst        asynchronous reset, active-low
//   req        per-requester word-available flags
//   din        flattened requester data, slice i = din[i*DW +: DW]
//   gnt        one-hot/zero grant (combinational, forced 0 in reset)
//   fifo_full  FIFO full flag
//   fifo_we    registered FIFO write enable
//   fifo_din   registered FIFO write data
//   owner      current / last burst owner
//   busy       1 while the FSM is in BURST (this is the FSM state)
module fifo_wr_arbiter #(
  parameter int NREQ     = 4,
  parameter int DW       = 4,
  parameter int MAXBURST = 4,
  localparam int PW      = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int CW      = $clog2(MAXBURST + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] din,
  output logic [NREQ-1:0]    gnt,
  input  logic               fifo_full,
  output logic               fifo_we,
  output logic [DW-1:0]      fifo_din,
  output logic [PW-1:0]      owner,
  output logic               busy
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [PW-1:0]   r_ptr, w_ptr_nxt;
  logic [PW-1:0]   r_owner, w_owner_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic            r_fifo_we;
  logic [DW-1:0]   r_fifo_din;

  logic [PW-1:0]   w_win;
  logic            w_any;
  logic [PW-1:0]   w_idx;
  logic            w_xfer;
  logic [PW-1:0]   w_sel;

  // (a + k) mod NREQ. This is correct for NREQ values that are not powers of two.
  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] a, input int k);
    int s;
    s = int'(a) + k;
    return PW'(s % NREQ);
  endfunction

  // Round-robin search starting at r_ptr. The scan runs from the farthest
  // offset to the nearest one, so the nearest requester is assigned last and wins.
  always_comb begin
    w_win = '0;
    w_any = 1'b0;
    w_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_idx = wrap_add(r_ptr, k);
      if (req[w_idx]) begin
        w_any = 1'b1;
        w_win = w_idx;
      end
    end
  end

  assign w_xfer = |(gnt & req);
  assign w_sel  = (r_state == S_IDLE) ? w_win : r_owner;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_owner <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_owner <= w_owner_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_owner_nxt = r_owner;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_xfer) begin
          w_owner_nxt = w_win;
          if (MAXBURST == 1) begin
            // A single-word burst ends on the same edge that starts it.
            w_ptr_nxt = wrap_add(w_win, 1);
          end else begin
            w_state_nxt = S_BURST;
            w_cnt_nxt   = CW'(1);
          end
        end
      end
      S_BURST: begin
        // A dropped request ends the burst even while the FIFO is full.
        if (!req[r_owner] || (w_xfer && (r_cnt == CW'(MAXBURST - 1)))) begin
          w_state_nxt = S_IDLE;
          w_ptr_nxt   = wrap_add(r_owner, 1);
          w_cnt_nxt   = '0;
        end else if (w_xfer) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic. The grant is gated by rst so it drops at once on reset.
  always_comb begin
    gnt = '0;
    if (rst && !fifo_full) begin
      if (r_state == S_IDLE) begin
        if (w_any) gnt[w_win] = 1'b1;
      end else begin
        gnt[r_owner] = req[r_owner];
      end
    end
    busy  = (r_state == S_BURST);
    owner = r_owner;
  end

  // FIFO write register. The FIFO samples this on the following negedge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fifo_we  <= 1'b0;
      r_fifo_din <= '0;
    end else begin
      r_fifo_we <= w_xfer;
      if (w_xfer) r_fifo_din <= din[w_sel*DW +: DW];
    end
  end

  assign fifo_we  = r_fifo_we;
  assign fifo_din = r_fifo_din;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter.
// Producers and a 16-deep FIFO occupancy counter are modelled here.
// A reference arbiter model predicts the grants and pushes each accepted word
// into exp_q. A separate monitor pops exp_q on every fifo_we.
module tb_fifo_wr_arbiter;
  localparam int NREQ     = 4;
  localparam int DW       = 4;
  localparam int MAXBURST = 4;
  localparam int PW       = 2;
  localparam int DEPTH    = 16;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [NREQ-1:0]    req = '0;
  logic [NREQ*DW-1:0] din = '0;
  logic               fifo_full = 1'b0;
  logic [NREQ-1:0]    gnt;
  logic               fifo_we;
  logic [DW-1:0]      fifo_din;
  logic [PW-1:0]      owner;
  logic               busy;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW), .MAXBURST(MAXBURST)) dut (
    .clk(clk), .rst(rst), .req(req), .din(din), .gnt(gnt),
    .fifo_full(fifo_full), .fifo_we(fifo_we), .fifo_din(fifo_din),
    .owner(owner), .busy(busy)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [DW-1:0] exp_q[$];

  int fifo_cnt = 0;
  bit reads_en = 1'b0;
  int mode     = 0;   // 0 frozen, 1 random producers, 2 all requesting, 3 drain

  // Reference arbiter: burst bookkeeping kept as plain integers.
  bit m_busy  = 1'b0;
  int m_owner = 0;
  int m_ptr   = 0;
  int m_cnt   = 0;

  logic [NREQ-1:0] last_gnt;
  logic            last_busy;
  logic            last_full;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
  endtask

  function automatic logic [NREQ-1:0] model_gnt(input logic [NREQ-1:0] r, input logic full);
    logic [NREQ-1:0] g;
    g = '0;
    if (full) return g;
    if (m_busy) begin
      g[m_owner] = r[m_owner];
      return g;
    end
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (m_ptr + k) % NREQ;
      if (r[i]) begin
        g[i] = 1'b1;
        return g;
      end
    end
    return g;
  endfunction

  task automatic model_reset();
    m_busy = 1'b0; m_owner = 0; m_ptr = 0; m_cnt = 0;
  endtask

  task automatic model_release();
    m_busy = 1'b0;
    m_ptr  = (m_owner + 1) % NREQ;
    m_cnt  = 0;
  endtask

  task automatic model_step(input logic [NREQ-1:0] r, input logic [NREQ*DW-1:0] d,
                            input logic [NREQ-1:0] g);
    int w;
    w = -1;
    for (int i = 0; i < NREQ; i++) if (g[i] && r[i]) w = i;
    if (w >= 0) exp_q.push_back(d[w*DW +: DW]);
    if (!m_busy) begin
      if (w >= 0) begin
        m_owner = w;
        if (MAXBURST == 1) m_ptr = (w + 1) % NREQ;
        else begin
          m_busy = 1'b1;
          m_cnt  = 1;
        end
      end
    end else if (!r[m_owner]) begin
      model_release();
    end else if (w >= 0) begin
      m_cnt++;
      if (m_cnt == MAXBURST) model_release();
    end
  endtask

  // Producers: a word that was taken is replaced by a fresh one, or the request drops.
  task automatic drive_next(input logic [NREQ-1:0] g);
    if (mode == 0) return;
    for (int i = 0; i < NREQ; i++) begin
      if (req[i]) begin
        if (g[i]) begin
          if (mode == 2 || (mode == 1 && $urandom_range(0, 3) != 0))
            din[i*DW +: DW] = DW'($urandom_range(0, 15));
          else
            req[i] = 1'b0;
        end
      end else if ((mode == 1 && $urandom_range(0, 1) == 0) || mode == 2) begin
        req[i] = 1'b1;
        din[i*DW +: DW] = DW'($urandom_range(0, 15));
      end
    end
  endtask

  // One clock: compare the grant at mid-cycle, then step the model on the posedge.
  task automatic run_cycle();
    logic [NREQ-1:0] g;
    @(negedge clk);
    #1;
    g = model_gnt(req, fifo_full);
    check("gnt", gnt, g);
    check("busy", busy, m_busy);
    check("owner", owner, m_owner[PW-1:0]);
    last_gnt  = gnt;
    last_busy = busy;
    last_full = fifo_full;
    @(posedge clk);
    model_step(req, din, g);
    #1;
    drive_next(g);
  endtask

  // Scoreboard monitor. It also models the FIFO, which samples writes on the negedge.
  always @(negedge clk) begin
    if (fifo_we) begin
      check("write_not_full", (fifo_cnt < DEPTH) ? 32'd1 : 32'd0, 32'd1);
      check("write_expected", (exp_q.size() != 0) ? 32'd1 : 32'd0, 32'd1);
      if (exp_q.size() != 0) check("fifo_din", fifo_din, exp_q.pop_front());
      if (fifo_cnt < DEPTH) fifo_cnt++;
    end
    if (reads_en && fifo_cnt > 0 && $urandom_range(0, 2) == 0) fifo_cnt--;
    fifo_full = (fifo_cnt == DEPTH);
  end

  initial begin
    logic [7:0] g_pat;
    logic [7:0] b_pat;
    int k;

    // Reset values, with every requester asking (the grant must stay 0).
    rst = 1'b0;
    req = '1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt", gnt, 0);
    check("rst_we", fifo_we, 0);
    check("rst_din", fifo_din, 0);
    check("rst_busy", busy, 0);
    check("rst_owner", owner, 0);
    model_reset();

    // A lone requester 2 with 4'hA streams two back-to-back bursts.
    req = 4'b0100;
    din = NREQ*DW'($urandom);
    din[2*DW +: DW] = 4'hA;
    mode = 0;
    rst = 1'b1;
    g_pat = '0;
    b_pat = '0;
    repeat (8) begin
      run_cycle();
      g_pat = {g_pat[6:0], last_gnt[2]};
      b_pat = {b_pat[6:0], last_busy};
    end
    check("solo_gnt_pattern", g_pat, 8'hFF);
    check("solo_busy_pattern", b_pat, 8'b0111_0111);
    req = '0;
    run_cycle();

    // Random producers, with random FIFO reads.
    reads_en = 1'b1;
    mode = 1;
    repeat (300) run_cycle();

    // All requesters held high: owners rotate in round-robin order.
    mode = 2;
    repeat (60) run_cycle();

    // Reset in the middle of a burst owned by requester 1.
    k = 0;
    while (k < 60 && !(m_busy && m_owner == 1)) begin
      run_cycle();
      k++;
    end
    check("reached_burst_owner1", (m_busy && m_owner == 1) ? 32'd1 : 32'd0, 32'd1);
    rst = 1'b0;
    #1;
    check("midrst_gnt", gnt, 0);
    check("midrst_we", fifo_we, 0);
    check("midrst_busy", busy, 0);
    exp_q.delete();
    model_reset();
    #2;
    rst = 1'b1;
    run_cycle();
    check("first_gnt_after_rst", last_gnt, last_full ? 4'b0000 : 4'b0001);
    repeat (40) run_cycle();

    // No reads: the FIFO fills to exactly 16 and the writes stop.
    reads_en = 1'b0;
    mode = 1;
    repeat (150) run_cycle();
    check("fill_count", fifo_cnt, DEPTH);
    check("fill_full", fifo_full, 1);
    check("fill_gnt_zero", last_gnt, 0);

    // Drain: reads resume, no new requests, every pending word reaches the FIFO.
    reads_en = 1'b1;
    mode = 3;
    repeat (250) run_cycle();
    check("drained_req", req, 0);
    check("drained_sb", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
